// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared W-stage encodings for the writeback register file
// Used by writeback_regfile (optional macro WB_REGFILE_BYPASS_EN) and wb_load_ext.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RS_ALU = 2'b00,
    RS_MEM = 2'b01,
    RS_PC4 = 2'b10
  } result_src_t;

  typedef enum logic [2:0] {
    RW_NONE   = 3'b000,
    RW_WORD   = 3'b001,
    RW_BYTE_S = 3'b010,
    RW_HALF_S = 3'b011,
    RW_BYTE_U = 3'b100,
    RW_HALF_U = 3'b101
  } regwrite_kind_t;

  localparam logic [4:0] REG_A0 = 5'd10;

endpackage

// File: rtl/wb_load_ext.sv
// rtl/wb_load_ext.sv - load lane select and sign/zero extension
// Combinational; half lanes ignore offset bit 0 since misaligned loads trap upstream.
module wb_load_ext
  import pipeline_pkg::*;
(
  input  logic [2:0]  i_kind,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_word,
  output logic [31:0] o_value
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte  = i_word[8*i_offset +: 8];
    w_half  = i_offset[1] ? i_word[31:16] : i_word[15:0];
    o_value = i_word;
    case (i_kind)
      RW_BYTE_S: o_value = {{24{w_byte[7]}}, w_byte};
      RW_HALF_S: o_value = {{16{w_half[15]}}, w_half};
      RW_BYTE_U: o_value = {24'd0, w_byte};
      RW_HALF_U: o_value = {16'd0, w_half};
      default:   o_value = i_word;
    endcase
  end

endmodule

// File: rtl/writeback_regfile.sv
// rtl/writeback_regfile.sv - RV32I writeback mux, 32x32 register file and a0 tap
// Macro WB_REGFILE_BYPASS_EN makes decode reads see the same-cycle W-stage write.
module writeback_regfile
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            RegWriteW,
  input  logic [1:0]            ResultSrcW,
  input  logic [DATA_WIDTH-1:0] ALUResultW,
  input  logic [ADDR_WIDTH-1:0] RdW,
  input  logic [DATA_WIDTH-1:0] ReadDataW,
  input  logic [DATA_WIDTH-1:0] PCPlus4W,
  input  logic [ADDR_WIDTH-1:0] RA1D,
  input  logic [ADDR_WIDTH-1:0] RA2D,
  output logic [DATA_WIDTH-1:0] RD1D,
  output logic [DATA_WIDTH-1:0] RD2D,
  output logic [DATA_WIDTH-1:0] ResultW,
  output logic                  WeW,
  output logic [DATA_WIDTH-1:0] a0
);

  logic [DATA_WIDTH-1:0] r_regs [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] r_a0;
  logic [DATA_WIDTH-1:0] w_load;
  logic [DATA_WIDTH-1:0] w_result;
  logic [DATA_WIDTH-1:0] w_rd1;
  logic [DATA_WIDTH-1:0] w_rd2;
  logic                  w_we;

  wb_load_ext u_load_ext (
    .i_kind   (RegWriteW),
    .i_offset (ALUResultW[1:0]),
    .i_word   (ReadDataW),
    .o_value  (w_load)
  );

  always_comb begin
    w_result = ALUResultW;
    case (ResultSrcW)
      RS_MEM:  w_result = w_load;
      RS_PC4:  w_result = PCPlus4W;
      default: w_result = ALUResultW;
    endcase
  end

  assign w_we = (RegWriteW != RW_NONE) && (RdW != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**ADDR_WIDTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_we) begin
      r_regs[RdW] <= w_result;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a0 <= '0;
    end else if (w_we && (RdW == REG_A0)) begin
      r_a0 <= w_result;
    end
  end

`ifdef WB_REGFILE_BYPASS_EN
  // Bypass is suppressed in reset so reads stay at the cleared storage value.
  assign w_rd1 = (w_we && !rst && (RA1D == RdW)) ? w_result : r_regs[RA1D];
  assign w_rd2 = (w_we && !rst && (RA2D == RdW)) ? w_result : r_regs[RA2D];
`else
  assign w_rd1 = r_regs[RA1D];
  assign w_rd2 = r_regs[RA2D];
`endif

  assign RD1D    = (RA1D == '0) ? '0 : w_rd1;
  assign RD2D    = (RA2D == '0) ? '0 : w_rd2;
  assign ResultW = w_result;
  assign WeW     = w_we;
  assign a0      = r_a0;

endmodule

// File: tb/tb_writeback_regfile.sv
// tb/tb_writeback_regfile.sv - self-checking bench for writeback_regfile
// Expected read results follow WB_REGFILE_BYPASS_EN when it is defined for the build.
module tb_writeback_regfile;

  logic        clk;
  logic        rst;
  logic [2:0]  RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ALUResultW;
  logic [4:0]  RdW;
  logic [31:0] ReadDataW;
  logic [31:0] PCPlus4W;
  logic [4:0]  RA1D;
  logic [4:0]  RA2D;
  logic [31:0] RD1D;
  logic [31:0] RD2D;
  logic [31:0] ResultW;
  logic        WeW;
  logic [31:0] a0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_a0;

  typedef struct {
    logic [2:0]  kind;
    logic [1:0]  off;
    logic [31:0] word;
    logic [31:0] exp;
  } ext_vec_t;

  ext_vec_t vecs [14];

  writeback_regfile dut (
    .clk        (clk),
    .rst        (rst),
    .RegWriteW  (RegWriteW),
    .ResultSrcW (ResultSrcW),
    .ALUResultW (ALUResultW),
    .RdW        (RdW),
    .ReadDataW  (ReadDataW),
    .PCPlus4W   (PCPlus4W),
    .RA1D       (RA1D),
    .RA2D       (RA2D),
    .RD1D       (RD1D),
    .RD2D       (RD2D),
    .ResultW    (ResultW),
    .WeW        (WeW),
    .a0         (a0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: load extension from plain shift/mask arithmetic.
  function automatic logic [31:0] m_ext(input logic [2:0] kind, input logic [1:0] off,
                                        input logic [31:0] word);
    logic [31:0] b, h;
    b = (word >> (32'(off) * 8)) & 32'hFF;
    h = (word >> (32'(off / 2) * 16)) & 32'hFFFF;
    case (kind)
      3'd2:    return (b > 127) ? b - 32'd256 : b;
      3'd3:    return (h > 32767) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] m_result();
    if (ResultSrcW == 2'd1) return m_ext(RegWriteW, ALUResultW[1:0], ReadDataW);
    if (ResultSrcW == 2'd2) return PCPlus4W;
    return ALUResultW;
  endfunction

  function automatic logic m_we();
    return (RegWriteW != 0) && (RdW != 0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0 || rst) return 32'd0;
`ifdef WB_REGFILE_BYPASS_EN
    if (m_we() && a == RdW) return m_result();
`endif
    return m_regs[a];
  endfunction

  task automatic set_w(input logic [2:0] kind, input logic [1:0] src, input logic [31:0] alu,
                       input logic [4:0] rd, input logic [31:0] rdata, input logic [31:0] pc4);
    RegWriteW  = kind;
    ResultSrcW = src;
    ALUResultW = alu;
    RdW        = rd;
    ReadDataW  = rdata;
    PCPlus4W   = pc4;
  endtask

  task automatic step();
    logic [31:0] r;
    logic        we;
    r  = m_result();
    we = m_we();
    @(posedge clk);
    if (we && !rst) begin
      m_regs[RdW] = r;
      if (RdW == 5'd10) m_a0 = r;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_a0 = 32'd0;
    rst  = 1'b1;
    set_w(3'd0, 2'd0, 32'd0, 5'd0, 32'd0, 32'd0);
    RA1D = 5'd5;
    RA2D = 5'd10;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rd1", RD1D, 32'd0);
    check("reset_a0", a0, 32'd0);
    rst = 1'b0;
    #1;

    // Basic ALU write then read next cycle
    set_w(3'd1, 2'd0, 32'hDEADBEEF, 5'd5, 32'd0, 32'd0);
    step();
    set_w(3'd0, 2'd0, 32'd0, 5'd0, 32'd0, 32'd0);
    RA1D = 5'd5;
    #1;
    check("alu_write_x5", RD1D, 32'hDEADBEEF);

    // Load extension table
    vecs[0]  = '{3'd2, 2'd0, 32'h80F07F01, 32'h00000001};
    vecs[1]  = '{3'd2, 2'd1, 32'h80F07F01, 32'h0000007F};
    vecs[2]  = '{3'd2, 2'd2, 32'h80F07F01, 32'hFFFFFFF0};
    vecs[3]  = '{3'd2, 2'd3, 32'h80F07F01, 32'hFFFFFF80};
    vecs[4]  = '{3'd5, 2'd2, 32'h80F07F01, 32'h000080F0};
    vecs[5]  = '{3'd3, 2'd2, 32'h80F07F01, 32'hFFFF80F0};
    vecs[6]  = '{3'd4, 2'd3, 32'h80F07F01, 32'h00000080};
    vecs[7]  = '{3'd4, 2'd2, 32'h80F07F01, 32'h000000F0};
    vecs[8]  = '{3'd3, 2'd0, 32'h80F07F01, 32'h00007F01};
    vecs[9]  = '{3'd3, 2'd3, 32'h80F07F01, 32'hFFFF80F0};
    vecs[10] = '{3'd5, 2'd1, 32'h80F07F01, 32'h00007F01};
    vecs[11] = '{3'd1, 2'd2, 32'h80F07F01, 32'h80F07F01};
    vecs[12] = '{3'd6, 2'd1, 32'h80F07F01, 32'h80F07F01};
    vecs[13] = '{3'd7, 2'd3, 32'h12345678, 32'h12345678};
    for (int i = 0; i < 14; i++) begin
      set_w(vecs[i].kind, 2'd1, {30'h1000, vecs[i].off}, 5'd3, vecs[i].word, 32'd0);
      #1;
      check($sformatf("ext_vec%0d", i), ResultW, vecs[i].exp);
      step();
      RA1D = 5'd3;
      set_w(3'd0, 2'd0, 32'd0, 5'd0, 32'd0, 32'd0);
      #1;
      check($sformatf("ext_store%0d", i), RD1D, vecs[i].exp);
    end

    // x0 is never written
    set_w(3'd1, 2'd0, 32'h1234, 5'd0, 32'd0, 32'd0);
    RA1D = 5'd0;
    #1;
    check("x0_wew", {31'd0, WeW}, 32'd0);
    step();
    check("x0_read", RD1D, 32'd0);

    // PC+4 link
    set_w(3'd1, 2'd2, 32'h55, 5'd1, 32'd0, 32'h104);
    step();
    set_w(3'd0, 2'd0, 32'd0, 5'd0, 32'd0, 32'd0);
    RA1D = 5'd1;
    #1;
    check("pc4_x1", RD1D, 32'h104);

    // Same-cycle read/write of x7
    set_w(3'd1, 2'd0, 32'h1, 5'd7, 32'd0, 32'd0);
    step();
    set_w(3'd1, 2'd0, 32'hCAFE, 5'd7, 32'd0, 32'd0);
    RA2D = 5'd7;
    #1;
`ifdef WB_REGFILE_BYPASS_EN
    check("same_cycle_rd2", RD2D, 32'hCAFE);
`else
    check("same_cycle_rd2", RD2D, 32'h1);
`endif
    step();
    set_w(3'd0, 2'd0, 32'd0, 5'd0, 32'd0, 32'd0);
    #1;
    check("next_cycle_rd2", RD2D, 32'hCAFE);

    // a0 tap
    set_w(3'd1, 2'd0, 32'h2A, 5'd10, 32'd0, 32'd0);
    #1;
    check("a0_before_edge", a0, 32'd0);
    step();
    check("a0_after_edge", a0, 32'h2A);
    set_w(3'd1, 2'd0, 32'h99, 5'd11, 32'd0, 32'd0);
    step();
    check("a0_hold_x11", a0, 32'h2A);

    // Randomized against the reference model
    for (int i = 0; i < 400; i++) begin
      set_w(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom,
            5'($urandom_range(0, 31)), $urandom, $urandom);
      if ($urandom_range(0, 3) == 0) RdW = 5'd10;
      RA1D = ($urandom_range(0, 2) == 0) ? RdW : 5'($urandom_range(0, 31));
      RA2D = 5'($urandom_range(0, 31));
      #1;
      check("rnd_result", ResultW, m_result());
      check("rnd_wew", {31'd0, WeW}, {31'd0, m_we()});
      check("rnd_rd1", RD1D, m_read(RA1D));
      check("rnd_rd2", RD2D, m_read(RA2D));
      step();
      check("rnd_a0", a0, m_a0);
    end

    // Fill x1..x31, then assert reset mid-cycle
    for (int i = 1; i < 32; i++) begin
      set_w(3'd1, 2'd0, 32'hA5000000 + 32'(i), 5'(i), 32'd0, 32'd0);
      step();
    end
    set_w(3'd1, 2'd0, 32'h77, 5'd4, 32'd0, 32'd0);
    RA1D = 5'd1;
    RA2D = 5'd31;
    #2;
    rst = 1'b1;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_a0 = 32'd0;
    #1;
    check("async_rst_a0", a0, 32'd0);
    check("async_rst_rd1", RD1D, 32'd0);
    check("async_rst_rd2", RD2D, 32'd0);
    check("rst_result_comb", ResultW, 32'h77);
    for (int i = 0; i < 32; i++) begin
      RA1D = 5'(i);
      RA2D = 5'(31 - i);
      #1;
      check($sformatf("rst_read_x%0d", i), RD1D, 32'd0);
      check($sformatf("rst_read2_x%0d", 31 - i), RD2D, 32'd0);
    end
    set_w(3'd0, 2'd0, 32'd0, 5'd0, 32'd0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    RA1D = 5'd4;
    #1;
    check("rst_write_dropped", RD1D, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0x%08h expected 0x%08h", 32'd0, 32'd1);
    $fatal(1, "timeout");
  end

endmodule
